// File: rtl/multicycle_control_unit_pkg.sv
// Shared definitions for the multi-cycle sequencer: FSM states, opclass codes
// and instruction field positions.
package multicycle_control_unit_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    FETCH  = 3'd1,
    DECODE = 3'd2,
    EXEC   = 3'd3,
    MEM    = 3'd4,
    WB     = 3'd5,
    TRAP   = 3'd6
  } state_t;

  localparam logic [2:0] OPC_MEM   = 3'b000;
  localparam logic [2:0] OPC_CTRL  = 3'b010;
  localparam logic [2:0] OPC_ARITH = 3'b100;

  localparam int OPC_HI    = 31;
  localparam int OPC_LO    = 29;
  localparam int ALU_OP_HI = 26;
  localparam int ALU_OP_LO = 24;
  localparam int SUB_BIT   = 24;
  localparam int IMM_HI    = 15;
  localparam int IMM_LO    = 0;

endpackage

// File: rtl/multicycle_control_unit_instr_decode.sv
// Combinational instruction field decode for the multi-cycle sequencer.
// An all-zero word is a NOP and takes priority over the memory class.
module instr_decode
  import multicycle_control_unit_pkg::*;
#(
  parameter int INSTR_W = 32
) (
  input  logic [INSTR_W-1:0] ir,
  output logic               is_nop,
  output logic               is_mem,
  output logic               is_ctrl,
  output logic               is_arith,
  output logic               is_illegal,
  output logic               sub,
  output logic [2:0]         alu_op,
  output logic [15:0]        imm16
);

  logic [2:0] opclass;

  always_comb begin
    opclass    = ir[OPC_HI:OPC_LO];
    is_nop     = (ir == '0);
    is_mem     = !is_nop && (opclass == OPC_MEM);
    is_ctrl    = !is_nop && (opclass == OPC_CTRL);
    is_arith   = !is_nop && (opclass == OPC_ARITH);
    is_illegal = !is_nop && !is_mem && !is_ctrl && !is_arith;
    sub        = ir[SUB_BIT];
    alu_op     = ir[ALU_OP_HI:ALU_OP_LO];
    imm16      = ir[IMM_HI:IMM_LO];
  end

endmodule

// File: rtl/multicycle_control_unit.sv
// Moore sequencer for the multi-cycle processor: owns PC and IR, steps the
// datapath through fetch/decode/execute/memory/writeback.
module multicycle_control_unit
  import multicycle_control_unit_pkg::*;
#(
  parameter int                ADDR_W      = 16,
  parameter int                INSTR_W     = 32,
  parameter logic [ADDR_W-1:0] RESET_PC    = '0,
  parameter int                MEM_TIMEOUT = 15,
  parameter int                CNT_W       = 16
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic               halt,
  input  logic [INSTR_W-1:0] instr,
  input  logic               alu_zero,
  input  logic               dmem_ready,
  output logic [ADDR_W-1:0]  inst_address,
  output logic [INSTR_W-1:0] ir,
  output logic               ir_write,
  output logic               alu_en,
  output logic [2:0]         alu_op,
  output logic               alu_src_imm,
  output logic               mem_read,
  output logic               mem_write,
  output logic               reg_write,
  output logic               retire,
  output logic [CNT_W-1:0]   retired_count,
  output logic [2:0]         state,
  output logic               error
);

  localparam int TMO_W = $clog2(MEM_TIMEOUT + 1);

  state_t            cur_state, state_n;
  logic [ADDR_W-1:0] pc, pc_n, pc_inc;
  logic [TMO_W-1:0]  tmo;
  logic              retire_n, load_ir, tmo_clr, tmo_inc;

  logic        is_nop, is_mem, is_ctrl, is_arith, is_illegal, sub;
  logic [2:0]  dec_alu_op;
  logic [15:0] imm16;

  instr_decode #(.INSTR_W(INSTR_W)) u_decode (
    .ir         (ir),
    .is_nop     (is_nop),
    .is_mem     (is_mem),
    .is_ctrl    (is_ctrl),
    .is_arith   (is_arith),
    .is_illegal (is_illegal),
    .sub        (sub),
    .alu_op     (dec_alu_op),
    .imm16      (imm16)
  );

  assign inst_address = pc;
  assign state        = cur_state;
  assign pc_inc       = pc + ADDR_W'(1);

  always_comb begin
    state_n  = cur_state;
    pc_n     = pc;
    retire_n = 1'b0;
    load_ir  = 1'b0;
    tmo_clr  = 1'b0;
    tmo_inc  = 1'b0;
    unique case (cur_state)
      IDLE: if (start) state_n = FETCH;
      FETCH: begin
        if (halt) begin
          state_n = IDLE;
        end else begin
          load_ir = 1'b1;
          state_n = DECODE;
        end
      end
      DECODE: begin
        if (is_nop) begin
          retire_n = 1'b1;
          pc_n     = pc_inc;
          state_n  = FETCH;
        end else if (is_illegal) begin
          state_n = TRAP;
        end else begin
          state_n = EXEC;
        end
      end
      EXEC: begin
        if (is_arith) begin
          state_n = WB;
        end else if (is_mem) begin
          tmo_clr = 1'b1;
          state_n = MEM;
        end else if (is_ctrl) begin
          retire_n = 1'b1;
          pc_n     = (!sub || alu_zero) ? ADDR_W'(imm16) : pc_inc;
          state_n  = FETCH;
        end else begin
          state_n = TRAP;
        end
      end
      // Ready is checked first so it wins over the terminal timeout count.
      MEM: begin
        if (dmem_ready) begin
          if (sub) begin
            retire_n = 1'b1;
            pc_n     = pc_inc;
            state_n  = FETCH;
          end else begin
            state_n = WB;
          end
        end else if (tmo == TMO_W'(MEM_TIMEOUT - 1)) begin
          state_n = TRAP;
        end else begin
          tmo_inc = 1'b1;
        end
      end
      WB: begin
        retire_n = 1'b1;
        pc_n     = pc_inc;
        state_n  = FETCH;
      end
      TRAP: state_n = TRAP;
      default: state_n = TRAP;
    endcase
  end

  // Strobes are registered from the next state so each is high for exactly
  // the cycles spent in its state.
  always_ff @(posedge clk) begin
    if (reset) begin
      cur_state     <= IDLE;
      pc            <= RESET_PC;
      ir            <= '0;
      tmo           <= '0;
      ir_write      <= 1'b0;
      alu_en        <= 1'b0;
      alu_op        <= '0;
      alu_src_imm   <= 1'b0;
      mem_read      <= 1'b0;
      mem_write     <= 1'b0;
      reg_write     <= 1'b0;
      retire        <= 1'b0;
      retired_count <= '0;
      error         <= 1'b0;
    end else begin
      cur_state <= state_n;
      pc        <= pc_n;
      if (load_ir) ir <= instr;
      if (tmo_clr) tmo <= '0;
      else if (tmo_inc) tmo <= tmo + TMO_W'(1);
      ir_write    <= (state_n == FETCH);
      alu_en      <= (state_n == EXEC) && (is_arith || is_mem);
      alu_op      <= (state_n == EXEC) ? dec_alu_op : '0;
      alu_src_imm <= (state_n == EXEC) && is_mem;
      mem_read    <= (state_n == MEM) && !sub;
      mem_write   <= (state_n == MEM) && sub;
      reg_write   <= (state_n == WB);
      retire      <= retire_n;
      if (retire_n && (retired_count != '1)) retired_count <= retired_count + CNT_W'(1);
      if (state_n == TRAP) error <= 1'b1;
    end
  end

endmodule
